// File: rtl/note_player.sv
// Song-command player: sequences WAIT/LOAD/PLAY/ACK for each ROM word and renders
// tones as a square wave on Q; BUSY dips for one cycle to step the song address.
module note_player #(
    parameter int CLK_HZ = 12_000_000,
    parameter int GAP_MS = 10,
    parameter int BEAT0  = 125
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [11:0] COMMAND,
    output logic        BUSY,
    output logic        Q
);
    localparam int     MS_DIV   = CLK_HZ / 1000;
    localparam int     MS_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam longint HALF_MAX = (longint'(CLK_HZ) * 50) / 26163;
    localparam int     HW       = $clog2(HALF_MAX + 1);
    localparam logic [13:0] GAP_REM = 14'(GAP_MS);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT1, S_WAIT2, S_LOAD, S_PLAY, S_ACK, S_STOP
    } state_t;

    // Half-period in clocks for each semitone of octave 4 (frequencies in centi-Hz).
    function automatic int half_of(input int s);
        longint f;
        case (s)
            1:       f = 27718;
            2:       f = 29366;
            3:       f = 31113;
            4:       f = 32963;
            5:       f = 34923;
            6:       f = 36999;
            7:       f = 39200;
            8:       f = 41530;
            9:       f = 44000;
            10:      f = 46616;
            11:      f = 49388;
            default: f = 26163;
        endcase
        return int'((longint'(CLK_HZ) * 50) / f);
    endfunction

    logic [HW-1:0] half_tbl [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_pitch
        assign half_tbl[gi] = HW'(half_of(gi));
    end

    state_t         state_reg, state_next;
    logic [9:0]     beat_ms_reg, beat_ms_next;
    logic [13:0]    rem_ms_reg, rem_ms_next;
    logic [MS_W-1:0] ms_cnt_reg, ms_cnt_next;
    logic [HW-1:0]  phase_reg, phase_next;
    logic [HW-1:0]  half_reg, half_next;
    logic           tone_reg, tone_next;
    logic           silent_reg, silent_next;
    logic           busy_reg, busy_next;
    logic           q_reg, q_next;

    logic [4:0]     dur;
    logic           ms_tick;
    logic           phase_wrap;

    assign dur        = (COMMAND[3:0] == 4'd0) ? 5'd16 : {1'b0, COMMAND[3:0]};
    assign ms_tick    = (ms_cnt_reg == MS_W'(MS_DIV - 1));
    assign phase_wrap = (phase_reg == half_reg - HW'(1));

    always_comb begin
        state_next   = state_reg;
        beat_ms_next = beat_ms_reg;
        rem_ms_next  = rem_ms_reg;
        ms_cnt_next  = ms_cnt_reg;
        phase_next   = phase_reg;
        half_next    = half_reg;
        tone_next    = tone_reg;
        silent_next  = silent_reg;

        if (!EN) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:  state_next = S_WAIT1;
                S_WAIT1: state_next = S_WAIT2;
                S_WAIT2: state_next = S_LOAD;
                S_LOAD: begin
                    if (COMMAND == 12'hFFF) begin
                        state_next = S_STOP;
                    end else if (!COMMAND[11]) begin
                        state_next  = S_PLAY;
                        rem_ms_next = {4'b0, beat_ms_reg} * {9'b0, dur};
                        ms_cnt_next = '0;
                        phase_next  = '0;
                        tone_next   = 1'b0;
                        half_next   = half_tbl[COMMAND[9:6]] >> COMMAND[5:4];
                        silent_next = (COMMAND[9:8] == 2'b11);
                    end else begin
                        state_next = S_ACK;
                        if (COMMAND[10] == 1'b0) begin
                            beat_ms_next = (COMMAND[9:0] == 10'd0) ? 10'd1 : COMMAND[9:0];
                        end
                    end
                end
                S_PLAY: begin
                    ms_cnt_next = ms_tick ? '0 : ms_cnt_reg + MS_W'(1);
                    if (ms_tick) begin
                        rem_ms_next = rem_ms_reg - 14'd1;
                        if (rem_ms_reg == 14'd1) begin
                            state_next = S_ACK;
                        end
                    end
                    // Phase keeps running through the articulation gap.
                    if (phase_wrap) begin
                        phase_next = '0;
                        tone_next  = ~tone_reg;
                    end else begin
                        phase_next = phase_reg + HW'(1);
                    end
                end
                S_ACK:   state_next = S_WAIT1;
                S_STOP:  state_next = S_STOP;
                default: state_next = S_IDLE;
            endcase
        end

        busy_next = (state_next == S_WAIT1) || (state_next == S_WAIT2) ||
                    (state_next == S_LOAD)  || (state_next == S_PLAY);
        q_next    = (state_next == S_PLAY) && !silent_next && tone_next &&
                    (rem_ms_next > GAP_REM);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= S_IDLE;
            beat_ms_reg <= 10'(BEAT0);
            rem_ms_reg  <= '0;
            ms_cnt_reg  <= '0;
            phase_reg   <= '0;
            half_reg    <= '0;
            tone_reg    <= 1'b0;
            silent_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            q_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            beat_ms_reg <= beat_ms_next;
            rem_ms_reg  <= rem_ms_next;
            ms_cnt_reg  <= ms_cnt_next;
            phase_reg   <= phase_next;
            half_reg    <= half_next;
            tone_reg    <= tone_next;
            silent_reg  <= silent_next;
            busy_reg    <= busy_next;
            q_reg       <= q_next;
        end
    end

    assign BUSY = busy_reg;
    assign Q    = q_reg;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: each command pushes its expected BUSY/Q profile to a
// scoreboard queue, which is popped and compared when BUSY drops.
module tb_note_player;
    localparam int CLK_HZ = 100_000;
    localparam int GAP_MS = 10;
    localparam int MS     = CLK_HZ / 1000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic [11:0] COMMAND;
    logic        BUSY;
    logic        Q;

    always #5 CLK = ~CLK;

    note_player #(.CLK_HZ(CLK_HZ), .GAP_MS(GAP_MS), .BEAT0(125)) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .COMMAND(COMMAND), .BUSY(BUSY), .Q(Q)
    );

    typedef struct {
        int busy_cyc;
        int rises;
        int first_rise;
        int last_high;
    } prof_t;

    prof_t exp_q[$];
    int    n_checks   = 0;
    int    n_pass     = 0;
    int    model_beat = 125;
    int    freq_chz [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                             36999, 39200, 41530, 44000, 46616, 49388};

    // Issue one command, observe its BUSY window, compare against the model.
    task automatic play(input logic [11:0] cmd);
        prof_t e, got;
        int    bd, a, h, m;
        bit    ok, qp;
        e = '{default: 0};
        if (cmd == 12'hFFF || cmd[11:10] == 2'b11) begin
            e.busy_cyc = 3;
        end else if (cmd[11:10] == 2'b10) begin
            model_beat = (cmd[9:0] == 10'd0) ? 1 : int'(cmd[9:0]);
            e.busy_cyc = 3;
        end else begin
            bd = model_beat * ((cmd[3:0] == 4'd0) ? 16 : int'(cmd[3:0]));
            e.busy_cyc = 3 + bd * MS;
            a = (bd > GAP_MS) ? (bd - GAP_MS) * MS : 0;
            if (cmd[9:6] < 4'd12 && a > 0) begin
                h = (CLK_HZ * 50 / freq_chz[cmd[9:6]]) >> cmd[5:4];
                e.rises = ((a - 1) / h + 1) / 2;
                if (e.rises > 0) begin
                    e.first_rise = 4 + h;
                    m = 2 * e.rises - 1;
                    e.last_high = 3 + (((m + 1) * h < a) ? (m + 1) * h : a);
                end
            end
        end
        exp_q.push_back(e);
        COMMAND = cmd;

        got = '{default: 0};
        ok  = 1'b0;
        qp  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            got.busy_cyc = 1;
            ok = 1'b0;
            for (int k = 0; k < e.busy_cyc + 50; k++) begin
                @(negedge CLK);
                if (!BUSY) begin
                    ok = 1'b1;
                    break;
                end
                got.busy_cyc++;
                if (Q) begin
                    got.last_high = got.busy_cyc;
                    if (!qp) begin
                        got.rises++;
                        if (got.first_rise == 0) got.first_rise = got.busy_cyc;
                    end
                end
                qp = Q;
            end
        end

        e = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            $display("FAIL handshake cmd=%h: BUSY window not seen within budget", cmd);
            return;
        end
        n_pass++;
        n_checks++;
        if (got.busy_cyc !== e.busy_cyc)
            $display("FAIL busy_cycles cmd=%h got=%0d want=%0d", cmd, got.busy_cyc, e.busy_cyc);
        else n_pass++;
        n_checks++;
        if (got.rises !== e.rises)
            $display("FAIL q_rises cmd=%h got=%0d want=%0d", cmd, got.rises, e.rises);
        else n_pass++;
        n_checks++;
        if (got.first_rise !== e.first_rise)
            $display("FAIL first_rise cmd=%h got=%0d want=%0d", cmd, got.first_rise, e.first_rise);
        else n_pass++;
        n_checks++;
        if (got.last_high !== e.last_high)
            $display("FAIL last_high cmd=%h got=%0d want=%0d", cmd, got.last_high, e.last_high);
        else n_pass++;
        n_checks++;
        if (Q !== 1'b0)
            $display("FAIL q_at_ack cmd=%h got=%b want=0", cmd, Q);
        else n_pass++;
        $display("cmd=%h busy=%0d rises=%0d first=%0d last=%0d", cmd,
                 got.busy_cyc, got.rises, got.first_rise, got.last_high);
    endtask

    task automatic test_reset();
        RST_N = 1'b0; EN = 1'b0; COMMAND = 12'h000;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", BUSY); else n_pass++;
        n_checks++;
        if (Q !== 1'b0) $display("FAIL reset_q got=%b want=0", Q); else n_pass++;
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL idle_without_en got=%b want=0", BUSY); else n_pass++;
    endtask

    task automatic test_tone();
        EN = 1'b1;
        play(12'h001);
    endtask

    task automatic test_tempo();
        play(12'h80A);
        play(12'h002);
        play(12'h011);
        play(12'h012);
    endtask

    task automatic test_rest_and_len();
        play(12'h302);
        play(12'hC00);
        play(12'h800);
        play(12'h00F);
        play(12'h000);
    endtask

    task automatic test_stop();
        int bad;
        play(12'hFFF);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            COMMAND = 12'($urandom_range(0, 4095));
            @(negedge CLK);
            if (BUSY !== 1'b0 || Q !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL stop_hold active_cycles got=%0d want=0", bad); else n_pass++;
        EN = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b0) $display("FAIL stop_to_idle busy got=%b want=0", BUSY); else n_pass++;
        EN = 1'b1;
        play(12'h00F);
    endtask

    task automatic test_abort();
        play(12'h814);
        COMMAND = 12'h001;
        repeat (601) @(negedge CLK);
        n_checks++;
        if (Q !== 1'b1) $display("FAIL abort_pre_q got=%b want=1", Q); else n_pass++;
        EN = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || Q !== 1'b0)
            $display("FAIL abort_idle busy/q got=%b%b want=00", BUSY, Q);
        else n_pass++;
        EN = 1'b1;
        play(12'h002);
    endtask

    task automatic test_async_reset();
        int bad;
        COMMAND = 12'h001;
        repeat (300) @(negedge CLK);
        n_checks++;
        if (BUSY !== 1'b1 || Q !== 1'b1)
            $display("FAIL pre_reset busy/q got=%b%b want=11", BUSY, Q);
        else n_pass++;
        #3;
        RST_N = 1'b0;
        EN    = 1'b0;
        #1;
        n_checks++;
        if (BUSY !== 1'b0 || Q !== 1'b0)
            $display("FAIL async_reset busy/q got=%b%b want=00", BUSY, Q);
        else n_pass++;
        model_beat = 125;
        @(negedge CLK);
        RST_N = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || Q !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL post_reset_idle active_cycles got=%0d want=0", bad); else n_pass++;
        EN = 1'b1;
        play(12'h001);
    endtask

    initial begin
        test_reset();
        test_tone();
        test_tempo();
        test_rest_and_len();
        test_stop();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
